// File: rtl/hazard_stall_controller.sv
// RAW interlock and branch-flush sequencer for the 16-bit in-order pipeline.
// Tracks in-flight register writes from DE through MW and freezes decode on a hazard.
//
// state | meaning
// RUN   | normal issue
// STALL | decode held on a RAW hazard
// FLUSH | wrong-path cleanup after a taken branch
module hazard_stall_controller #(
  parameter int REG_AW       = 4,
  parameter int PIPE_DEPTH   = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic              id_src1_used,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src2_used,
  input  logic [REG_AW-1:0] id_reg_dest,
  input  logic              id_writes,
  input  logic              branch_taken,
  output logic              pc_stall,
  output logic              fd_stall,
  output logic              fd_flush,
  output logic              de_bubble,
  output logic              issue,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [PIPE_DEPTH-1:0] sb_v;
  logic [REG_AW-1:0] sb_dest [PIPE_DEPTH];
  logic              hazard;
  logic              flushing;

  // MW still counts as a hazard: the regfile has no write-before-read bypass.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (sb_v[i] && ((id_src1_used && (sb_dest[i] == id_src1)) ||
                      (id_src2_used && (sb_dest[i] == id_src2))))
        hazard = 1'b1;
    end
    hazard = hazard & id_valid;
  end

  assign flushing  = branch_taken | (state_q == FLUSH);
  assign issue     = id_valid & ~hazard & ~flushing;
  assign de_bubble = ~issue;
  assign pc_stall  = hazard & ~flushing;
  assign fd_stall  = pc_stall;
  assign fd_flush  = flushing;
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        sb_v[i]    <= 1'b0;
        sb_dest[i] <= '0;
      end
    end else begin
      for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
        sb_v[i]    <= sb_v[i-1];
        sb_dest[i] <= sb_dest[i-1];
      end
      sb_v[0]    <= issue & id_writes;
      sb_dest[0] <= id_reg_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // A taken branch overrides any stall and reloads the flush timer, even mid-flush.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (branch_taken) begin
      state_d = FLUSH;
      fcnt_d  = FC_LOAD;
    end else begin
      case (state_q)
        RUN:     if (hazard) state_d = STALL;
        STALL:   if (!hazard) state_d = RUN;
        FLUSH: begin
          if (fcnt_q == '0) state_d = RUN;
          else              fcnt_d  = fcnt_q - 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (pc_stall && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller; a second instance with a 2-bit
// counter shares the stimulus so counter saturation is reachable quickly.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_src1;
  logic       id_src1_used;
  logic [3:0] id_src2;
  logic       id_src2_used;
  logic [3:0] id_reg_dest;
  logic       id_writes;
  logic       branch_taken;

  logic        pc_stall, fd_stall, fd_flush, de_bubble, issue;
  logic [1:0]  state;
  logic [15:0] stall_count;

  logic        s_pc_stall, s_fd_stall, s_fd_flush, s_de_bubble, s_issue;
  logic [1:0]  s_state;
  logic [1:0]  s_stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_stall_controller dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_reg_dest(id_reg_dest), .id_writes(id_writes), .branch_taken(branch_taken),
    .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush),
    .de_bubble(de_bubble), .issue(issue), .state(state), .stall_count(stall_count)
  );

  hazard_stall_controller #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_reg_dest(id_reg_dest), .id_writes(id_writes), .branch_taken(branch_taken),
    .pc_stall(s_pc_stall), .fd_stall(s_fd_stall), .fd_flush(s_fd_flush),
    .de_bubble(s_de_bubble), .issue(s_issue), .state(s_state), .stall_count(s_stall_count)
  );

  // One pipeline cycle: inputs change 1ns after the edge, outputs settle by +3ns.
  task automatic step(input logic v, input logic [3:0] s1, input logic s1u,
                      input logic [3:0] s2, input logic s2u, input logic [3:0] dst,
                      input logic wr, input logic br);
    @(posedge clk);
    #1;
    id_valid = v; id_src1 = s1; id_src1_used = s1u; id_src2 = s2; id_src2_used = s2u;
    id_reg_dest = dst; id_writes = wr; branch_taken = br;
    #2;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic writer(input logic [3:0] dst);
    step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, dst, 1'b1, 1'b0);
  endtask

  // Present a reader of src until it issues; returns stalled cycles (99 if it never issues).
  task automatic consume(input logic [3:0] src, output int stalls);
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, src, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      if (issue === 1'b1) return;
      stalls++;
    end
    stalls = 99;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_valid = 0; id_src1 = 0; id_src1_used = 0; id_src2 = 0; id_src2_used = 0;
    id_reg_dest = 0; id_writes = 0; branch_taken = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    n_checks++;
    if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
    n_checks++;
    if ({pc_stall, fd_stall, fd_flush, issue, de_bubble} !== 5'b00001)
      $display("FAIL reset_outputs: got %b expected 00001", {pc_stall, fd_stall, fd_flush, issue, de_bubble});
    else n_pass++;
    n_checks++;
    if (stall_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", stall_count); else n_pass++;
    n_checks++;
    if (s_stall_count !== 2'd0) $display("FAIL reset_sat_count: got %0d expected 0", s_stall_count); else n_pass++;
  endtask

  task automatic test_basic_stall();
    writer(4'd3);
    n_checks++;
    if (issue !== 1'b1) $display("FAIL writer_issue: got %b expected 1", issue); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      n_checks++;
      if ({pc_stall, fd_stall, de_bubble, issue} !== 4'b1110)
        $display("FAIL stall_cycle%0d: got %b expected 1110", k, {pc_stall, fd_stall, de_bubble, issue});
      else n_pass++;
      if (k == 2) begin
        n_checks++;
        if (state !== 2'd1) $display("FAIL stall_state: got %0d expected 1", state); else n_pass++;
      end
    end
    step(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++;
    if ({pc_stall, issue} !== 2'b01) $display("FAIL release_issue: got %b expected 01", {pc_stall, issue}); else n_pass++;
    n_checks++;
    if (stall_count !== 16'd3) $display("FAIL basic_count: got %0d expected 3", stall_count); else n_pass++;
    idle();
    n_checks++;
    if (state !== 2'd0) $display("FAIL back_to_run: got %0d expected 0", state); else n_pass++;
  endtask

  task automatic test_no_stall();
    step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0);
    step(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++;
    if ({pc_stall, issue} !== 2'b01) $display("FAIL nowrite_reader: got %b expected 01", {pc_stall, issue}); else n_pass++;
    writer(4'd3);
    step(1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++;
    if (pc_stall !== 1'b0) $display("FAIL invalid_reader: got %b expected 0", pc_stall); else n_pass++;
    step(1'b1, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++;
    if ({pc_stall, issue} !== 2'b01) $display("FAIL src2_unused: got %b expected 01", {pc_stall, issue}); else n_pass++;
    repeat (3) idle();
  endtask

  task automatic test_two_writers();
    int stalls;
    writer(4'd3);
    writer(4'd5);
    consume(4'd5, stalls);
    n_checks++;
    if (stalls != 3) $display("FAIL read_r5_stalls: got %0d expected 3", stalls); else n_pass++;
    repeat (3) idle();
    writer(4'd3);
    writer(4'd5);
    consume(4'd3, stalls);
    n_checks++;
    if (stalls != 2) $display("FAIL read_r3_stalls: got %0d expected 2", stalls); else n_pass++;
    repeat (3) idle();
    n_checks++;
    if (stall_count !== 16'd8) $display("FAIL cumulative_count: got %0d expected 8", stall_count); else n_pass++;
    n_checks++;
    if (s_stall_count !== 2'd3) $display("FAIL sat_count: got %0d expected 3", s_stall_count); else n_pass++;
  endtask

  task automatic test_flush_during_stall();
    logic issued;
    writer(4'd3);
    step(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    issued = issue;
    n_checks++;
    if (pc_stall !== 1'b1) $display("FAIL pre_branch_stall: got %b expected 1", pc_stall); else n_pass++;
    step(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    issued = issued | issue;
    n_checks++;
    if ({fd_flush, pc_stall, fd_stall, de_bubble} !== 4'b1001)
      $display("FAIL branch_cycle: got %b expected 1001", {fd_flush, pc_stall, fd_stall, de_bubble});
    else n_pass++;
    idle();
    issued = issued | issue;
    n_checks++;
    if ({fd_flush, pc_stall, state} !== 4'b1010)
      $display("FAIL flush_cycle: got %b expected 1010", {fd_flush, pc_stall, state});
    else n_pass++;
    idle();
    n_checks++;
    if ({fd_flush, state} !== 3'b000) $display("FAIL after_flush: got %b expected 000", {fd_flush, state}); else n_pass++;
    n_checks++;
    if (issued !== 1'b0) $display("FAIL killed_issue: got %b expected 0", issued); else n_pass++;
    n_checks++;
    if (stall_count !== 16'd9) $display("FAIL flush_count: got %0d expected 9", stall_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    idle();
    n_checks++;
    if ({fd_flush, state} !== 3'b110) $display("FAIL reload_flush: got %b expected 110", {fd_flush, state}); else n_pass++;
    idle();
    n_checks++;
    if (state !== 2'd0) $display("FAIL reload_done: got %0d expected 0", state); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int stalls;
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    idle();
    n_checks++;
    if (state !== 2'd2) $display("FAIL pre_reset_flush: got %0d expected 2", state); else n_pass++;
    rst = 1'b1;
    idle();
    rst = 1'b0;
    n_checks++;
    if ({state, fd_flush} !== 3'b000) $display("FAIL reset_mid_flush: got %b expected 000", {state, fd_flush}); else n_pass++;
    n_checks++;
    if (stall_count !== 16'd0) $display("FAIL reset_mid_count: got %0d expected 0", stall_count); else n_pass++;
    writer(4'd3);
    step(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    n_checks++;
    if ({issue, pc_stall, state} !== 4'b1000)
      $display("FAIL reset_mid_stall: got %b expected 1000", {issue, pc_stall, state});
    else n_pass++;
    idle();
    writer(4'd3);
    consume(4'd3, stalls);
    repeat (3) idle();
    writer(4'd3);
    writer(4'd5);
    consume(4'd3, stalls);
    repeat (3) idle();
    n_checks++;
    if (s_stall_count !== 2'd3) $display("FAIL sat_hold: got %0d expected 3", s_stall_count); else n_pass++;
    n_checks++;
    if (stall_count !== 16'd5) $display("FAIL post_reset_count: got %0d expected 5", stall_count); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_stall();
    test_no_stall();
    test_two_writers();
    test_flush_during_stall();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
